// File: rtl/frame_seq_pkg.sv
// Shared types, button indices and the camera clamp helper for the frame sequencer.
package frame_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PHYSICS,
        CAM,
        SETTLE,
        ENV,
        COMMIT
    } state_t;

    localparam int unsigned BTN_XN = 3;
    localparam int unsigned BTN_XP = 2;
    localparam int unsigned BTN_YN = 1;
    localparam int unsigned BTN_YP = 0;

    // Wide enough to hold any WORLD_BITS+1 sum as well as the int clamp limits.
    localparam int unsigned CLAMP_W = 34;

    function automatic logic signed [CLAMP_W-1:0] clamp_world(
        input logic signed [CLAMP_W-1:0] value,
        input logic signed [CLAMP_W-1:0] lo,
        input logic signed [CLAMP_W-1:0] hi
    );
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/frame_sequencer_camera_update.sv
// Combinational next-camera position: follow target or single-button step, clamped.
module camera_update
    import frame_seq_pkg::*;
#(
    parameter int WORLD_BITS = 18,
    parameter int CAM_STEP   = 5,
    parameter int CAM_MIN    = -65536,
    parameter int CAM_MAX    = 65535
)(
    input  logic                         follow_en,
    input  logic [3:0]                   btn,
    input  logic signed [WORLD_BITS-1:0] target_x,
    input  logic signed [WORLD_BITS-1:0] target_y,
    input  logic signed [WORLD_BITS-1:0] cam_x,
    input  logic signed [WORLD_BITS-1:0] cam_y,
    output logic signed [WORLD_BITS-1:0] next_x,
    output logic signed [WORLD_BITS-1:0] next_y
);

    localparam int unsigned SUM_W = WORLD_BITS + 1;
    localparam logic signed [SUM_W-1:0]   STEP = SUM_W'(CAM_STEP);
    localparam logic signed [CLAMP_W-1:0] LO   = CLAMP_W'(CAM_MIN);
    localparam logic signed [CLAMP_W-1:0] HI   = CLAMP_W'(CAM_MAX);

    logic signed [SUM_W-1:0] dx;
    logic signed [SUM_W-1:0] dy;
    logic signed [SUM_W-1:0] sum_x;
    logic signed [SUM_W-1:0] sum_y;

    // Pick the highest-priority button delta, or the follow target, one bit wider than world.
    always_comb begin
        dx = '0;
        dy = '0;
        if (btn[BTN_XN]) begin
            dx = -STEP;
        end else if (btn[BTN_XP]) begin
            dx = STEP;
        end else if (btn[BTN_YN]) begin
            dy = -STEP;
        end else if (btn[BTN_YP]) begin
            dy = STEP;
        end

        if (follow_en) begin
            sum_x = SUM_W'(target_x);
            sum_y = SUM_W'(target_y);
        end else begin
            sum_x = SUM_W'(cam_x) + dx;
            sum_y = SUM_W'(cam_y) + dy;
        end
    end

    assign next_x = WORLD_BITS'(clamp_world(CLAMP_W'(sum_x), LO, HI));
    assign next_y = WORLD_BITS'(clamp_world(CLAMP_W'(sum_y), LO, HI));

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: physics step, camera update, environment stream, commit strobe.
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int WORLD_BITS     = 18,
    parameter int CAM_STEP       = 5,
    parameter int CAM_INIT_X     = 640,
    parameter int CAM_INIT_Y     = 360,
    parameter int CAM_MIN        = -65536,
    parameter int CAM_MAX        = 65535,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1200000
)(
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         new_frame_in,
    input  logic [3:0]                   btn_in,
    input  logic                         follow_en_in,
    input  logic signed [WORLD_BITS-1:0] target_x_in,
    input  logic signed [WORLD_BITS-1:0] target_y_in,
    output logic                         physics_start_out,
    input  logic                         physics_done_in,
    output logic                         env_start_out,
    input  logic                         env_done_in,
    output logic signed [WORLD_BITS-1:0] camera_x_out,
    output logic signed [WORLD_BITS-1:0] camera_y_out,
    output logic                         commit_out,
    output logic                         busy_out,
    output logic [7:0]                   overrun_count_out,
    output logic                         timeout_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]             wait_cnt;
    logic                         wait_expired;
    logic                         physics_ok;
    logic                         env_ok;
    logic                         physics_start_d;
    logic                         env_start_d;
    logic                         commit_d;
    logic                         timeout_hit;
    logic                         cam_load;
    logic signed [WORLD_BITS-1:0] cam_next_x;
    logic signed [WORLD_BITS-1:0] cam_next_y;

    // A done level on the first cycle of a wait state is stale from the previous frame.
    assign physics_ok   = physics_done_in && (wait_cnt != '0);
    assign env_ok       = env_done_in && (wait_cnt != '0);
    assign wait_expired = (wait_cnt == CNT_TIMEOUT);

    camera_update #(
        .WORLD_BITS (WORLD_BITS),
        .CAM_STEP   (CAM_STEP),
        .CAM_MIN    (CAM_MIN),
        .CAM_MAX    (CAM_MAX)
    ) u_camera_update (
        .follow_en (follow_en_in),
        .btn       (btn_in),
        .target_x  (target_x_in),
        .target_y  (target_y_in),
        .cam_x     (camera_x_out),
        .cam_y     (camera_y_out),
        .next_x    (cam_next_x),
        .next_y    (cam_next_y)
    );

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; done beats timeout when both land on the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (new_frame_in) state_next = PHYSICS;
            PHYSICS: if (physics_ok || wait_expired) state_next = CAM;
            CAM:     state_next = SETTLE;
            SETTLE:  if (wait_cnt == CNT_SETTLE) state_next = ENV;
            ENV: begin
                if (env_ok) begin
                    state_next = COMMIT;
                end else if (wait_expired) begin
                    state_next = IDLE;
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: strobes are computed from the transition and registered below.
    always_comb begin
        busy_out        = (state != IDLE);
        physics_start_d = (state == IDLE) && (state_next == PHYSICS);
        env_start_d     = (state == SETTLE) && (state_next == ENV);
        commit_d        = (state == ENV) && (state_next == COMMIT);
        cam_load        = (state == CAM);
        timeout_hit     = ((state == PHYSICS) && !physics_ok && wait_expired) ||
                          ((state == ENV) && !env_ok && wait_expired);
    end

    // Registered outputs, camera, sticky flags and the shared wait counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            physics_start_out <= 1'b0;
            env_start_out     <= 1'b0;
            commit_out        <= 1'b0;
            camera_x_out      <= WORLD_BITS'(CAM_INIT_X);
            camera_y_out      <= WORLD_BITS'(CAM_INIT_Y);
            overrun_count_out <= '0;
            timeout_out       <= 1'b0;
            wait_cnt          <= '0;
        end else begin
            physics_start_out <= physics_start_d;
            env_start_out     <= env_start_d;
            commit_out        <= commit_d;
            if (cam_load) begin
                camera_x_out <= cam_next_x;
                camera_y_out <= cam_next_y;
            end
            if (timeout_hit) begin
                timeout_out <= 1'b1;
            end
            if (new_frame_in && (state != IDLE) && (overrun_count_out != '1)) begin
                overrun_count_out <= overrun_count_out + 8'd1;
            end
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if ((state == PHYSICS) || (state == SETTLE) || (state == ENV)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: expected strobe cycles are queued when a frame
// is launched and popped when the DUT raises the strobe.
module tb_frame_sequencer;

    localparam int WB = 18;

    typedef struct {
        longint c;
        longint x;
        longint y;
    } commit_t;

    logic                 clk_in;
    logic                 rst_in;
    logic                 new_frame_in;
    logic [3:0]           btn_in;
    logic                 follow_en_in;
    logic signed [WB-1:0] target_x_in;
    logic signed [WB-1:0] target_y_in;
    logic                 physics_done_in;
    logic                 env_done_in;

    logic                 a_physics_start, a_env_start, a_commit, a_busy, a_timeout;
    logic signed [WB-1:0] a_cam_x, a_cam_y;
    logic [7:0]           a_overrun;

    logic                 b_physics_start, b_env_start, b_commit, b_busy, b_timeout;
    logic signed [WB-1:0] b_cam_x, b_cam_y;
    logic [7:0]           b_overrun;

    longint      cyc;
    int unsigned n_cmp;
    int unsigned n_bad;
    longint      phys_q[$];
    longint      env_q[$];
    commit_t     commit_q[$];
    longint      cam_ex, cam_ey, exp_ovr;

    frame_sequencer #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .new_frame_in      (new_frame_in),
        .btn_in            (btn_in),
        .follow_en_in      (follow_en_in),
        .target_x_in       (target_x_in),
        .target_y_in       (target_y_in),
        .physics_start_out (a_physics_start),
        .physics_done_in   (physics_done_in),
        .env_start_out     (a_env_start),
        .env_done_in       (env_done_in),
        .camera_x_out      (a_cam_x),
        .camera_y_out      (a_cam_y),
        .commit_out        (a_commit),
        .busy_out          (a_busy),
        .overrun_count_out (a_overrun),
        .timeout_out       (a_timeout)
    );

    frame_sequencer #(
        .CAM_MIN        (0),
        .CAM_INIT_X     (2),
        .TIMEOUT_CYCLES (100)
    ) dut_clamp (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .new_frame_in      (new_frame_in),
        .btn_in            (btn_in),
        .follow_en_in      (follow_en_in),
        .target_x_in       (target_x_in),
        .target_y_in       (target_y_in),
        .physics_start_out (b_physics_start),
        .physics_done_in   (physics_done_in),
        .env_start_out     (b_env_start),
        .env_done_in       (env_done_in),
        .camera_x_out      (b_cam_x),
        .camera_y_out      (b_cam_y),
        .commit_out        (b_commit),
        .busy_out          (b_busy),
        .overrun_count_out (b_overrun),
        .timeout_out       (b_timeout)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic expect_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Strobe monitor: each strobe must match the oldest queued expectation.
    always @(negedge clk_in) begin
        longint  want;
        commit_t ce;
        if (a_physics_start) begin
            want = 0;
            if (phys_q.size() != 0) want = phys_q.pop_front();
            expect_eq("physics_start_cycle", cyc, want);
        end
        if (a_env_start) begin
            want = 0;
            if (env_q.size() != 0) want = env_q.pop_front();
            expect_eq("env_start_cycle", cyc, want);
        end
        if (a_commit) begin
            ce = '{c: 0, x: 0, y: 0};
            if (commit_q.size() != 0) ce = commit_q.pop_front();
            expect_eq("commit_cycle", cyc, ce.c);
            expect_eq("commit_cam_x", a_cam_x, ce.x);
            expect_eq("commit_cam_y", a_cam_y, ce.y);
        end
    end

    // One full frame. dp: cycles from new_frame to physics_done; de: cycles from
    // env_start to env_done. mode 1 adds two new_frame pulses in ENV and one in COMMIT,
    // mode 2 holds new_frame high for the whole sequence.
    task automatic run_frame(input int dp, input int de, input bit stale, input int mode,
                             input longint ex, input longint ey);
        longint t0;
        int t_env, t_edone, t_com, t_end;
        t_env   = dp + 4;
        t_edone = t_env + de;
        t_com   = t_edone + 1;
        t_end   = t_com + 1;
        t0      = cyc;
        phys_q.push_back(t0 + 1);
        env_q.push_back(t0 + t_env);
        commit_q.push_back('{c: t0 + t_com, x: ex, y: ey});
        if (mode == 1) exp_ovr = exp_ovr + 3;
        if (mode == 2) exp_ovr = exp_ovr + t_com;
        if (exp_ovr > 255) exp_ovr = 255;
        for (int k = 0; k <= t_end; k++) begin
            new_frame_in    = (k == 0) ||
                              (mode == 1 && (k == t_env + 2 || k == t_env + 5 || k == t_com)) ||
                              (mode == 2 && k <= t_com);
            physics_done_in = (k == dp) || (stale && k < dp);
            env_done_in     = (k == t_edone);
            if (k == 1) expect_eq("busy_in_frame", a_busy, 1);
            if (k == t_end) begin
                expect_eq("busy_after_commit", a_busy, 0);
                expect_eq("cam_x_after_frame", a_cam_x, ex);
                expect_eq("cam_y_after_frame", a_cam_y, ey);
                expect_eq("overrun_count", a_overrun, exp_ovr);
            end
            tick(1);
        end
        new_frame_in    = 1'b0;
        physics_done_in = 1'b0;
        env_done_in     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        longint t0;
        n_cmp           = 0;
        n_bad           = 0;
        exp_ovr         = 0;
        rst_in          = 1'b1;
        new_frame_in    = 1'b0;
        btn_in          = 4'b0000;
        follow_en_in    = 1'b0;
        target_x_in     = '0;
        target_y_in     = '0;
        physics_done_in = 1'b0;
        env_done_in     = 1'b0;
        tick(3);

        expect_eq("reset_cam_x", a_cam_x, 640);
        expect_eq("reset_cam_y", a_cam_y, 360);
        expect_eq("reset_busy", a_busy, 0);
        expect_eq("reset_strobes", {a_physics_start, a_env_start, a_commit}, 0);
        expect_eq("reset_overrun", a_overrun, 0);
        expect_eq("reset_timeout", a_timeout, 0);
        expect_eq("reset_b_cam_x", b_cam_x, 2);
        rst_in = 1'b0;
        tick(2);

        // Nominal frame: commit 55 cycles after new_frame, camera untouched.
        cam_ex = 640;
        cam_ey = 360;
        run_frame(10, 40, 0, 0, cam_ex, cam_ey);

        // x- outranks y+; the clamp instance pins at CAM_MIN=0.
        btn_in = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            cam_ex = cam_ex - 5;
            run_frame(4, 6, 0, 0, cam_ex, cam_ey);
            expect_eq("clamp_b_cam_x", b_cam_x, 0);
        end

        btn_in = 4'b0100;
        cam_ex = cam_ex + 5;
        run_frame(4, 6, 0, 0, cam_ex, cam_ey);
        btn_in = 4'b0010;
        cam_ey = cam_ey - 5;
        run_frame(4, 6, 0, 0, cam_ex, cam_ey);
        btn_in = 4'b0001;
        cam_ey = cam_ey + 5;
        run_frame(4, 6, 0, 0, cam_ex, cam_ey);
        btn_in = 4'b1111;
        cam_ex = cam_ex - 5;
        run_frame(4, 6, 0, 0, cam_ex, cam_ey);

        // Follow overrides buttons and clamps to the world limits.
        btn_in       = 4'b1000;
        follow_en_in = 1'b1;
        target_x_in  = 18'sd100000;
        target_y_in  = -18'sd70000;
        run_frame(4, 6, 0, 0, 65535, -65536);
        expect_eq("follow_b_cam_x", b_cam_x, 65535);
        expect_eq("follow_b_cam_y", b_cam_y, 0);
        target_x_in = 18'sd1234;
        target_y_in = -18'sd4321;
        cam_ex      = 1234;
        cam_ey      = -4321;
        run_frame(4, 6, 0, 0, cam_ex, cam_ey);
        follow_en_in = 1'b0;
        btn_in       = 4'b0000;

        // Stale physics_done held through IDLE: accepted on the second PHYSICS cycle.
        run_frame(2, 5, 1, 0, cam_ex, cam_ey);

        // Overruns in ENV and COMMIT are counted and dropped.
        run_frame(3, 20, 0, 1, cam_ex, cam_ey);

        // Continuous new_frame drives the count into saturation.
        for (int i = 0; i < 4; i++) begin
            run_frame(10, 80, 0, 2, cam_ex, cam_ey);
        end

        // env_done never arrives: timeout after 100 ENV cycles, no commit.
        t0 = cyc;
        phys_q.push_back(t0 + 1);
        env_q.push_back(t0 + 14);
        for (int k = 0; k <= 114; k++) begin
            new_frame_in    = (k == 0);
            physics_done_in = (k == 10);
            env_done_in     = 1'b0;
            if (k == 113) begin
                expect_eq("env_last_wait_busy", a_busy, 1);
                expect_eq("env_last_wait_timeout", a_timeout, 0);
            end
            if (k == 114) begin
                expect_eq("env_timeout_busy", a_busy, 0);
                expect_eq("env_timeout_flag", a_timeout, 1);
            end
            tick(1);
        end
        new_frame_in    = 1'b0;
        physics_done_in = 1'b0;
        tick(5);
        expect_eq("timeout_sticky", a_timeout, 1);

        // Asynchronous reset in the middle of PHYSICS.
        t0 = cyc;
        phys_q.push_back(t0 + 1);
        new_frame_in = 1'b1;
        tick(1);
        new_frame_in = 1'b0;
        tick(2);
        rst_in = 1'b1;
        #1;
        expect_eq("midrst_busy", a_busy, 0);
        expect_eq("midrst_cam_x", a_cam_x, 640);
        expect_eq("midrst_cam_y", a_cam_y, 360);
        expect_eq("midrst_overrun", a_overrun, 0);
        expect_eq("midrst_timeout", a_timeout, 0);
        expect_eq("midrst_strobes", {a_physics_start, a_env_start, a_commit}, 0);
        tick(1);
        rst_in = 1'b0;
        for (int k = 0; k < 30; k++) begin
            physics_done_in = (k % 3 == 0);
            env_done_in     = (k % 5 == 0);
            tick(1);
        end
        physics_done_in = 1'b0;
        env_done_in     = 1'b0;
        expect_eq("postrst_busy", a_busy, 0);
        expect_eq("postrst_cam_x", a_cam_x, 640);

        expect_eq("physics_start_missing", phys_q.size(), 0);
        expect_eq("env_start_missing", env_q.size(), 0);
        expect_eq("commit_missing", commit_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
